sram_arbiter: RTL and testbench

- Shares one external 16-bit asynchronous SRAM between the instruction-fetch port (IF stage) and the data-memory port (MA stage) of the 5-stage RISC-V core.
- Arbitrates between the two requesters and splits each 32-bit access into two 16-bit SRAM half-cycles.
- Returns read data and a completion pulse to the winning port.
- Sits between the pipeline stages and the board SRAM pins; the hazard unit stalls on missing acks.

---
 rtl/sram_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit async SRAM between the fetch (IF) and data (DM) ports.
// Ports: i_clk/i_rst_n clock and async active-low reset;
//   i_if_req/i_if_addr -> o_if_rdata/o_if_ack  fetch port (read only);
//   i_dm_req/i_dm_wren/i_dm_addr/i_dm_wdata/i_dm_bmask -> o_dm_rdata/o_dm_ack  data port;
//   o_sram_addr/o_sram_dq_o/o_sram_dq_oe/i_sram_dq_i and active-low strobes to the SRAM pins.
module sram_arbiter #(
   parameter int ADDR_W   = 18,
   parameter int WAIT_CYC = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_if_req,
   input  logic [31:0]       i_if_addr,
   output logic [31:0]       o_if_rdata,
   output logic              o_if_ack,
   input  logic              i_dm_req,
   input  logic              i_dm_wren,
   input  logic [31:0]       i_dm_addr,
   input  logic [31:0]       i_dm_wdata,
   input  logic [3:0]        i_dm_bmask,
   output logic [31:0]       o_dm_rdata,
   output logic              o_dm_ack,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [15:0]       o_sram_dq_o,
   output logic              o_sram_dq_oe,
   input  logic [15:0]       i_sram_dq_i,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic              o_sram_lb_n,
   output logic              o_sram_ub_n
);
   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_ACK} state_t;
   localparam logic [1:0] LAST = 2'(WAIT_CYC - 1);
   state_t            r_state, w_nxt;
   logic [1:0]        r_cnt, w_cnt_nxt;
   logic              r_last, r_gnt, r_wr;
   logic [ADDR_W-2:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_bmask;
   logic [15:0]       r_lo;
   logic              w_pick_dm, w_done, w_idle, w_wr, w_hi;
   logic [ADDR_W-2:0] w_addr;
   logic [31:0]       w_wdata;
   logic [3:0]        w_bmask;
   logic [1:0]        w_mask;
   logic [15:0]       w_dq;
   logic              w_unused;
   assign w_unused = ^{i_if_addr[31:ADDR_W+1], i_if_addr[1:0], i_dm_addr[31:ADDR_W+1], i_dm_addr[1:0]};
   // r_last: 1 = data port won last; on a tie the other port wins
   assign w_pick_dm = i_dm_req & (~i_if_req | ~r_last);
   assign w_done    = r_cnt == LAST;
   assign w_idle    = r_state == S_IDLE;
   assign o_if_ack  = (r_state == S_ACK) & ~r_gnt;
   assign o_dm_ack  = (r_state == S_ACK) & r_gnt;
   always_comb begin
      w_nxt     = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         S_IDLE: w_nxt = (i_if_req | i_dm_req) ? S_LO : S_IDLE;
         S_LO: begin
            w_cnt_nxt = w_done ? 2'd0 : 2'(r_cnt + 2'd1);
            w_nxt     = w_done ? S_HI : S_LO;
         end
         S_HI: begin
            w_cnt_nxt = w_done ? 2'd0 : 2'(r_cnt + 2'd1);
            w_nxt     = w_done ? S_ACK : S_HI;
         end
         S_ACK: w_nxt = S_IDLE;
      endcase
   end
   // Operands come straight from the winning port on entry to LO, from the latches afterwards
   always_comb begin
      w_addr  = w_idle ? (w_pick_dm ? i_dm_addr[ADDR_W:2] : i_if_addr[ADDR_W:2]) : r_addr;
      w_wr    = w_idle ? (w_pick_dm & i_dm_wren) : r_wr;
      w_wdata = w_idle ? i_dm_wdata : r_wdata;
      w_bmask = w_idle ? i_dm_bmask : r_bmask;
      w_hi    = w_nxt == S_HI;
      w_mask  = w_hi ? w_bmask[3:2] : w_bmask[1:0];
      w_dq    = w_hi ? w_wdata[31:16] : w_wdata[15:0];
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= 2'd0;
         r_last       <= 1'b0;
         r_gnt        <= 1'b0;
         r_wr         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_bmask      <= '0;
         r_lo         <= '0;
         o_if_rdata   <= '0;
         o_dm_rdata   <= '0;
         o_sram_addr  <= '0;
         o_sram_dq_o  <= '0;
         o_sram_dq_oe <= 1'b0;
         o_sram_ce_n  <= 1'b1;
         o_sram_oe_n  <= 1'b1;
         o_sram_we_n  <= 1'b1;
         o_sram_lb_n  <= 1'b1;
         o_sram_ub_n  <= 1'b1;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_idle && w_nxt == S_LO) begin
            r_gnt   <= w_pick_dm;
            r_last  <= w_pick_dm;
            r_addr  <= w_addr;
            r_wr    <= w_wr;
            r_wdata <= w_wdata;
            r_bmask <= w_bmask;
         end
         if (w_nxt == S_LO || w_nxt == S_HI) begin
            o_sram_ce_n  <= 1'b0;
            o_sram_addr  <= {w_addr, w_hi};
            o_sram_oe_n  <= w_wr;
            o_sram_we_n  <= ~(w_wr & |w_mask);
            o_sram_lb_n  <= w_wr & ~w_mask[0];
            o_sram_ub_n  <= w_wr & ~w_mask[1];
            o_sram_dq_o  <= w_dq;
            o_sram_dq_oe <= w_wr;
         end else begin
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
            o_sram_dq_oe <= 1'b0;
         end
         if (r_state == S_LO && w_done)
            r_lo <= i_sram_dq_i;
         if (r_state == S_HI && w_done && !r_wr && r_gnt)
            o_dm_rdata <= {i_sram_dq_i, r_lo};
         if (r_state == S_HI && w_done && !r_wr && !r_gnt)
            o_if_rdata <= {i_sram_dq_i, r_lo};
      end
   end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed bench for sram_arbiter, WAIT_CYC=1 and WAIT_CYC=2 instances.
module tb_sram_arbiter;
   localparam int AW = 18;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic        if_req [2], dm_req [2], dm_wren [2], if_ack [2], dm_ack [2];
   logic        ce_n [2], oe_n [2], we_n [2], lb_n [2], ub_n [2], dq_oe [2];
   logic [31:0] if_addr [2], dm_addr [2], dm_wdata [2], if_rdata [2], dm_rdata [2];
   logic [3:0]  bmask [2];
   logic [AW-1:0] sa [2];
   logic [15:0] dq_o [2], dq_i [2];
   logic [15:0] sram [2][0:(1<<AW)-1];
   logic [31:0] ref_mem [2][0:(1<<(AW-1))-1];
   int checks = 0, errors = 0;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      sram_arbiter #(.ADDR_W(AW), .WAIT_CYC(g + 1)) dut (
         .i_clk(clk), .i_rst_n(rst_n),
         .i_if_req(if_req[g]), .i_if_addr(if_addr[g]), .o_if_rdata(if_rdata[g]), .o_if_ack(if_ack[g]),
         .i_dm_req(dm_req[g]), .i_dm_wren(dm_wren[g]), .i_dm_addr(dm_addr[g]), .i_dm_wdata(dm_wdata[g]),
         .i_dm_bmask(bmask[g]), .o_dm_rdata(dm_rdata[g]), .o_dm_ack(dm_ack[g]),
         .o_sram_addr(sa[g]), .o_sram_dq_o(dq_o[g]), .o_sram_dq_oe(dq_oe[g]), .i_sram_dq_i(dq_i[g]),
         .o_sram_ce_n(ce_n[g]), .o_sram_oe_n(oe_n[g]), .o_sram_we_n(we_n[g]),
         .o_sram_lb_n(lb_n[g]), .o_sram_ub_n(ub_n[g]));
      assign dq_i[g] = sram[g][sa[g]];
      always @(posedge clk) begin
         if (!ce_n[g] && !we_n[g] && !lb_n[g]) sram[g][sa[g]][7:0] <= dq_o[g][7:0];
         if (!ce_n[g] && !we_n[g] && !ub_n[g]) sram[g][sa[g]][15:8] <= dq_o[g][15:8];
      end
   end
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask
   function automatic logic [31:0] raddr();
      return ($urandom & 32'hFFF8_0000) | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
   endfunction
   task automatic drive(input int k, input bit p, input bit req);
      if (p) begin
         dm_req[k] = req; dm_wren[k] = 1'($urandom_range(0, 1)); dm_addr[k] = raddr();
         dm_wdata[k] = $urandom; bmask[k] = 4'($urandom);
      end else begin
         if_req[k] = req; if_addr[k] = raddr();
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 0; dm_req[k] = 0; dm_wren[k] = 0; if_addr[k] = 0;
         dm_addr[k] = 0; dm_wdata[k] = 0; bmask[k] = 0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic init_mem(input int k);
      for (int w = 0; w < 128; w++) begin
         ref_mem[k][w] = $urandom;
         sram[k][2*w]   = ref_mem[k][w][15:0];
         sram[k][2*w+1] = ref_mem[k][w][31:16];
      end
   endtask
   int ack_at, ack_cnt, oth_cnt, ce_cnt;
   logic [AW-1:0] s_addr [12];
   logic s_we [12], s_lb [12], s_ub [12], s_oe [12], s_dqoe [12];
   logic [15:0] s_dq [12];
   task automatic txn(input int k, input bit dm, input bit wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mk);
      ack_at = -1; ack_cnt = 0; oth_cnt = 0; ce_cnt = 0;
      dm_wren[k] = dm ? wr : 1'b1;
      dm_wdata[k] = wd; bmask[k] = mk;
      if (dm) begin dm_req[k] = 1; dm_addr[k] = addr; end
      else begin if_req[k] = 1; if_addr[k] = addr; end
      for (int c = 1; c < 12; c++) begin
         @(negedge clk);
         s_addr[c] = sa[k]; s_we[c] = we_n[k]; s_lb[c] = lb_n[k]; s_ub[c] = ub_n[k];
         s_oe[c] = oe_n[k]; s_dqoe[c] = dq_oe[k]; s_dq[c] = dq_o[k];
         if (!ce_n[k]) ce_cnt++;
         if (dm ? dm_ack[k] : if_ack[k]) begin
            ack_cnt++;
            if (ack_at < 0) ack_at = c;
            if_req[k] = 0; dm_req[k] = 0;
         end
         if (dm ? if_ack[k] : dm_ack[k]) oth_cnt++;
      end
      if_req[k] = 0; dm_req[k] = 0; dm_wren[k] = 0;
   endtask
   task automatic rand_run(input int k, input int n);
      int w = k + 1, free_at = 0, exp_at = -1, widx;
      bit busy = 0, cur = 0, last = 0, c_wr = 0;
      bit pend [2] = '{0, 0};
      logic [31:0] c_addr = 0, c_wd = 0, c_rd = 0;
      logic [31:0] exp_rd [2] = '{0, 0};
      logic [3:0] c_mk = 0;
      do_reset();
      init_mem(k);
      for (int m = 0; m < n; m++) begin
         @(negedge clk);
         chk("if_ack", 32'(if_ack[k]), 32'(busy && m == exp_at && !cur));
         chk("dm_ack", 32'(dm_ack[k]), 32'(busy && m == exp_at && cur));
         if (busy && m == exp_at) begin
            widx = int'(c_addr[AW:2]);
            for (int b = 0; b < 4; b++)
               if (c_wr && c_mk[b]) ref_mem[k][widx][8*b +: 8] = c_wd[8*b +: 8];
            if (!c_wr) exp_rd[cur] = c_rd;
            chk("if_rdata", if_rdata[k], exp_rd[0]);
            chk("dm_rdata", dm_rdata[k], exp_rd[1]);
            busy = 0; pend[cur] = 0;
            if (cur) dm_req[k] = 0; else if_req[k] = 0;
         end
         if (busy && $urandom_range(0, 3) == 0) drive(k, cur, 1'b0);
         for (int p = 0; p < 2; p++)
            if (!pend[p] && (m == 0 || $urandom_range(0, 2) != 0)) begin
               drive(k, p[0], 1'b1);
               pend[p] = 1;
            end
         if (!busy && m >= free_at && (if_req[k] || dm_req[k])) begin
            cur = (if_req[k] && dm_req[k]) ? !last : dm_req[k];
            last = cur;
            c_wr = cur & dm_wren[k];
            c_addr = cur ? dm_addr[k] : if_addr[k];
            c_wd = dm_wdata[k]; c_mk = bmask[k];
            c_rd = ref_mem[k][int'(c_addr[AW:2])];
            busy = 1; exp_at = m + 2*w + 1; free_at = exp_at + 1;
         end
      end
      if_req[k] = 0; dm_req[k] = 0;
      repeat (8) @(negedge clk);
   endtask
   initial begin
      do_reset();
      init_mem(0); init_mem(1);
      sram[0][8] = 16'h5678; sram[0][9] = 16'h1234;
      txn(0, 0, 0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF);
      chk("t1_ack_at", ack_at, 3);
      chk("t1_addr_lo", 32'(s_addr[1]), 8);
      chk("t1_addr_hi", 32'(s_addr[2]), 9);
      chk("t1_we_held", 32'(s_we[1] & s_we[2]), 1);
      chk("t1_rdata", if_rdata[0], 32'h1234_5678);
      chk("t1_ce_cycles", ce_cnt, 2);
      chk("t1_other_ack", oth_cnt, 0);
      txn(0, 1, 1, 32'h0000_0024, 32'hAABB_CCDD, 4'b0011);
      chk("t2_addr_lo", 32'(s_addr[1]), 32'h12);
      chk("t2_lo_strobes", {s_we[1], s_lb[1], s_ub[1], s_oe[1], s_dqoe[1]}, 5'b00011);
      chk("t2_lo_dq", 32'(s_dq[1]), 32'hCCDD);
      chk("t2_addr_hi", 32'(s_addr[2]), 32'h13);
      chk("t2_hi_we", 32'(s_we[2]), 1);
      chk("t2_ack_cnt", ack_cnt, 1);
      chk("t2_ack_at", ack_at, 3);
      chk("t2_mem_lo", 32'(sram[0][32'h12]), 32'hCCDD);
      chk("t2_mem_hi", 32'(sram[0][32'h13]), 32'(ref_mem[0][9][31:16]));
      txn(1, 1, 0, 32'h0000_0027, 32'h0, 4'h0);
      chk("t6_ce_cycles", ce_cnt, 4);
      chk("t6_ack_at", ack_at, 5);
      chk("t6_rdata", dm_rdata[1], ref_mem[1][9]);
      txn(0, 1, 0, 32'h0000_0014, 32'h0, 4'h0);
      chk("t5_pre_rdata", dm_rdata[0], ref_mem[0][5]);
      dm_req[0] = 1; dm_wren[0] = 0; dm_addr[0] = 32'h18;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_strobes", {ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], dq_oe[0]}, 6'b111110);
      chk("t5_rdata", dm_rdata[0], 0);
      chk("t5_addr", 32'(sa[0]), 0);
      dm_req[0] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      ack_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (dm_ack[0] || if_ack[0]) ack_cnt++;
      end
      chk("t5_no_ack", ack_cnt, 0);
      txn(0, 1, 0, 32'h0000_0018, 32'h0, 4'h0);
      chk("t5_after_ack_at", ack_at, 3);
      chk("t5_after_rdata", dm_rdata[0], ref_mem[0][6]);
      rand_run(0, 600);
      rand_run(1, 600);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
